// File: rtl/fpu_dispatch_if.sv
// Request/response channels between a caller and the FPU dispatch front-end.
interface fpu_dispatch_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_lo;
  logic [31:0]      rsp_hi;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_tag
  );
endinterface

// File: rtl/fpu_dispatch.sv
// Issue front-end for FPU_top: request FIFO, one-at-a-time issue, fixed-latency
// result capture and a valid/ready response register.
module fpu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 10,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fpu_dispatch_if.slave              bus,
  output logic [4:0]                 fpu_op_mask,
  output logic                       fpu_instr_received,
  output logic [31:0]                fpu_input_1,
  output logic [31:0]                fpu_input_2,
  input  logic [31:0]                fpu_reg_lo,
  input  logic [31:0]                fpu_reg_hi,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop, capture;
  state_t           state, next;
  logic [LW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;

  assign full          = (fifo_count == CW'(DEPTH));
  assign empty         = (fifo_count == '0);
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign head          = mem[rd_ptr];
  assign capture       = (state == WAIT) && (cnt == '0);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b, tag: bus.req_tag};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    pop  = 1'b0;
    case (state)
      IDLE:  if (!empty) begin pop = 1'b1; next = ISSUE; end
      ISSUE: next = WAIT;
      WAIT:  if (cnt == '0) next = RESP;
      RESP:  if (bus.rsp_ready) begin
               if (!empty) begin pop = 1'b1; next = ISSUE; end
               else next = IDLE;
             end
      default: next = IDLE;
    endcase
  end

  // Every pop lands in ISSUE, so registering pop yields a clean one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_instr_received <= 1'b0;
      fpu_op_mask        <= '0;
      fpu_input_1        <= '0;
      fpu_input_2        <= '0;
      tag_q              <= '0;
      cnt                <= '0;
    end else begin
      fpu_instr_received <= pop;
      if (pop) begin
        fpu_op_mask <= head.op;
        fpu_input_1 <= head.a;
        fpu_input_2 <= head.b;
        tag_q       <= head.tag;
      end
      if (state == ISSUE)                 cnt <= LW'(LATENCY - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_lo    <= '0;
      bus.rsp_hi    <= '0;
      bus.rsp_tag   <= '0;
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_lo    <= fpu_reg_lo;
      bus.rsp_hi    <= fpu_reg_hi;
      bus.rsp_tag   <= tag_q;
    end else if (state == RESP && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a fixed-latency FPU stand-in.
module tb_fpu_dispatch;
  localparam int DEPTH = 4, LATENCY = 10, TAG_W = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic [4:0]  fpu_op_mask;
  logic        fpu_instr_received;
  logic [31:0] fpu_input_1, fpu_input_2, fpu_reg_lo, fpu_reg_hi;
  logic        busy;
  logic [2:0]  fifo_count;
  int          errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_dispatch_if #(.TAG_W(TAG_W)) bus();

  fpu_dispatch #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fpu_op_mask(fpu_op_mask), .fpu_instr_received(fpu_instr_received),
    .fpu_input_1(fpu_input_1), .fpu_input_2(fpu_input_2),
    .fpu_reg_lo(fpu_reg_lo), .fpu_reg_hi(fpu_reg_hi),
    .busy(busy), .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FPU stand-in: result is valid only in the single cycle LATENCY after the pulse.
  function automatic logic [31:0] model_lo(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3f800000 && b == 32'h3f800000) return 32'h3f800000;
    if (a == 32'hbf000000 && b == 32'h43fa2000) return 32'hc37a2000;
    return a + b;
  endfunction
  function automatic logic [31:0] model_hi(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return a ^ b ^ {27'd0, op};
  endfunction

  int m = -1;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b;
  always @(posedge clk or posedge rst)
    if (rst) m <= -1;
    else if (fpu_instr_received) begin
      m <= LATENCY - 1; m_op <= fpu_op_mask; m_a <= fpu_input_1; m_b <= fpu_input_2;
    end else if (m >= 0) m <= m - 1;
  assign fpu_reg_lo = (m == 0) ? model_lo(m_a, m_b) : 32'hdeadbeef;
  assign fpu_reg_hi = (m == 0) ? model_hi(m_op, m_a, m_b) : 32'hbaadf00d;

  typedef struct { logic [31:0] lo, hi; logic [TAG_W-1:0] tag; int c; } rsp_t;
  rsp_t got[$];
  int   pulses[$];
  int   accepts[$];
  int   rv_cycles = 0;

  always @(negedge clk) if (!rst) begin
    if (fpu_instr_received) pulses.push_back(cyc);
    if (bus.req_valid && bus.req_ready) accepts.push_back(cyc);
    if (bus.rsp_valid) rv_cycles++;
    if (bus.rsp_valid && bus.rsp_ready) got.push_back('{bus.rsp_lo, bus.rsp_hi, bus.rsp_tag, cyc});
    if (m >= 0) begin
      chk("hold_input_1", fpu_input_1, m_a);
      chk("hold_input_2", fpu_input_2, m_b);
      chk("hold_op_mask", 32'(fpu_op_mask), 32'(m_op));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    got.delete(); pulses.delete(); accepts.delete(); rv_cycles = 0;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin step(); bus.req_valid = 1'b0; return; end
      step();
    end
    chk("send_timeout", 32'd1, 32'd0);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) return;
      step();
    end
    chk("rsp_timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({pfx, "_req_ready"}, 32'(bus.req_ready), 1);
    chk({pfx, "_fifo_count"}, 32'(fifo_count), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_instr"}, 32'(fpu_instr_received), 0);
    chk({pfx, "_op_mask"}, 32'(fpu_op_mask), 0);
    chk({pfx, "_input_1"}, fpu_input_1, 0);
    chk({pfx, "_input_2"}, fpu_input_2, 0);
    chk({pfx, "_rsp_lo"}, bus.rsp_lo, 0);
    chk({pfx, "_rsp_hi"}, bus.rsp_hi, 0);
    chk({pfx, "_rsp_tag"}, 32'(bus.rsp_tag), 0);
  endtask

  typedef struct { logic [4:0] op; logic [31:0] a, b; logic [TAG_W-1:0] tag; logic [31:0] lo, hi; } vec_t;
  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad, p0;
    logic acc;
    vecs[0] = '{5'd1,  32'h3f800000, 32'h3f800000, 4'd3,  32'h3f800000, 32'h00000001};
    vecs[1] = '{5'd2,  32'h00000010, 32'h00000020, 4'd7,  32'h00000030, 32'h00000032};
    vecs[2] = '{5'd3,  32'hffffffff, 32'h00000001, 4'd15, 32'h00000000, 32'hfffffffd};
    vecs[3] = '{5'h1f, 32'h12345678, 32'h11111111, 4'd0,  32'h23456789, 32'h03254776};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1; #1;
    chk_reset_outputs("reset");
    step(); step();
    rst = 1'b0;
    step();

    // Single ops from the table: latency and data.
    bus.rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      clear_logs();
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rsp(1, 60);
      chk("single_pulses", 32'(pulses.size()), 1);
      if (pulses.size() > 0 && accepts.size() > 0 && got.size() > 0) begin
        chk("single_issue_lat", 32'(pulses[0] - accepts[0]), 2);
        chk("single_rsp_lat", 32'(got[0].c - pulses[0]), LATENCY + 1);
        chk("single_lo", got[0].lo, vecs[i].lo);
        chk("single_hi", got[0].hi, vecs[i].hi);
        chk("single_tag", 32'(got[0].tag), 32'(vecs[i].tag));
      end
      chk("single_idle", 32'(busy), 0);
    end

    // Fill with the response stalled: DEPTH+1 accepted, then drain in order.
    bus.rsp_ready = 1'b0;
    clear_logs();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      bus.req_valid = 1'b1; bus.req_op = 5'd1; bus.req_a = 32'(k); bus.req_b = 32'd100;
      bus.req_tag = TAG_W'(k);
      acc = bus.req_ready;
      step();
      if (acc) k++;
    end
    chk("fill_accepted", 32'(k), 5);
    chk("fill_req_ready", 32'(bus.req_ready), 0);
    chk("fill_count", 32'(fifo_count), 4);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      acc = bus.req_ready;
      step();
      if (acc) begin k++; break; end
    end
    bus.req_valid = 1'b0;
    chk("fill_tag5_accepted", 32'(k), 6);
    wait_rsp(6, 200);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) begin
        chk("drain_tag", 32'(got[i].tag), 32'(i));
        chk("drain_lo", got[i].lo, 32'(100 + i));
      end
    step();

    // Backpressure: result and operands frozen, no issue while stalled.
    bus.rsp_ready = 1'b0;
    clear_logs();
    send(5'd1, 32'hbf000000, 32'h43fa2000, 4'd9);
    send(5'd2, 32'd5, 32'd6, 4'd10);
    for (int c = 0; c < 40 && !bus.rsp_valid; c++) step();
    chk("stall_valid", 32'(bus.rsp_valid), 1);
    p0 = pulses.size();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.rsp_valid || bus.rsp_lo !== 32'hc37a2000 || bus.rsp_tag !== 4'd9 || fpu_instr_received)
        bad++;
      step();
    end
    chk("stall_hold", 32'(bad), 0);
    chk("stall_no_issue", 32'(pulses.size()), 32'(p0));
    chk("stall_pulses", 32'(p0), 1);
    chk("stall_count", 32'(fifo_count), 1);
    bus.rsp_ready = 1'b1;
    wait_rsp(2, 60);
    if (got.size() >= 2) begin
      chk("stall_rsp0_lo", got[0].lo, 32'hc37a2000);
      chk("stall_rsp0_tag", 32'(got[0].tag), 9);
      chk("stall_rsp1_lo", got[1].lo, 32'd11);
      chk("stall_rsp1_tag", 32'(got[1].tag), 10);
    end
    step();

    // Back-to-back: issue spacing LATENCY+2, one-cycle responses in order.
    clear_logs();
    for (int i = 0; i < 3; i++) send(5'd3, 32'h100 * i, 32'd1, TAG_W'(4 + i));
    wait_rsp(3, 120);
    chk("b2b_pulses", 32'(pulses.size()), 3);
    if (pulses.size() == 3 && got.size() == 3) begin
      chk("b2b_gap01", 32'(pulses[1] - pulses[0]), LATENCY + 2);
      chk("b2b_gap12", 32'(pulses[2] - pulses[1]), LATENCY + 2);
      for (int i = 0; i < 3; i++) begin
        chk("b2b_tag", 32'(got[i].tag), 32'(4 + i));
        chk("b2b_lo", got[i].lo, 32'h100 * i + 1);
        chk("b2b_rsp_lat", 32'(got[i].c - pulses[i]), LATENCY + 1);
      end
    end
    chk("b2b_rsp_cycles", 32'(rv_cycles), 3);
    step();

    // Reset mid-WAIT with a second op queued: everything abandoned.
    clear_logs();
    send(5'd1, 32'd7, 32'd8, 4'd1);
    send(5'd1, 32'd9, 32'd9, 4'd2);
    for (int c = 0; c < 20 && pulses.size() == 0; c++) step();
    chk("midwait_pulse", 32'(pulses.size()), 1);
    for (int c = 0; c < 4; c++) step();
    #2 rst = 1'b1; #1;
    chk_reset_outputs("midwait_reset");
    step();
    rst = 1'b0;
    clear_logs();
    for (int c = 0; c < 20; c++) step();
    chk("midwait_no_rsp", 32'(rv_cycles), 0);
    chk("midwait_no_issue", 32'(pulses.size()), 0);
    chk("midwait_count", 32'(fifo_count), 0);
    chk("midwait_idle", 32'(busy), 0);
    send(5'd1, 32'h3f800000, 32'h3f800000, 4'd6);
    wait_rsp(1, 60);
    if (got.size() > 0) begin
      chk("after_reset_lo", got[0].lo, 32'h3f800000);
      chk("after_reset_tag", 32'(got[0].tag), 6);
    end
    chk("after_reset_pulses", 32'(pulses.size()), 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Issue front-end for `FPU_top`. It buffers FP operation requests in a small FIFO and issues them one at a time to the FPU with a single-cycle `instr_received` pulse. It holds the operands stable for the fixed FPU latency, captures `reg_lo`/`reg_hi`, and returns the result with its tag over a valid/ready response channel. `FPU_top` has no done signal, so this block is its sole sequencer.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `LATENCY`, 10: cycles from the issue pulse to result capture; ≥1.
- `TAG_W`, 4: width of the request tag.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; equals `!full`.
- `req_op`  in  5  opcode (`FMUL`, `FMAX`, `FMIN`, ...); passed through undecoded.
- `req_a`, `req_b`  in  32  IEEE-754 single operands.
- `req_tag`  in  TAG_W  caller tag.
- `fpu_op_mask`  out  5  to `FPU_top.op_mask`.
- `fpu_instr_received`  out  1  to `FPU_top.instr_received`.
- `fpu_input_1`, `fpu_input_2`  out  32  to `FPU_top.input_1`/`input_2`.
- `fpu_reg_lo`, `fpu_reg_hi`  in  32  from `FPU_top.reg_lo`/`reg_hi`.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_lo`, `rsp_hi`  out  32  captured result.
- `rsp_tag`  out  TAG_W  tag of the captured result.
- `busy`  out  1  FSM not in IDLE.
- `fifo_count`  out  $clog2(DEPTH+1)  occupancy.

## Operation
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push on `req_valid & req_ready`. Pop only when the FSM takes an entry.
  - Push and pop in the same cycle leaves `fifo_count` unchanged.
  - No bypass: `req_ready` is low whenever `fifo_count==DEPTH`, even if a pop occurs that cycle.
- Issue registers `fpu_op_mask`, `fpu_input_1`, `fpu_input_2`, and the internal tag load only on pop. They hold their value until the next pop.
- FSM states:
  - IDLE: if FIFO is non-empty, pop and go to ISSUE; otherwise stay.
  - ISSUE, one cycle: `fpu_instr_received`=1; load counter with LATENCY-1; go to WAIT.
  - WAIT: `fpu_instr_received`=0; decrement the counter. When counter==0, capture `fpu_reg_lo`/`fpu_reg_hi` and the tag into the `rsp_*` registers and go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`: if FIFO is non-empty, pop and go to ISSUE; else go to IDLE. Without `rsp_ready`, stay; `rsp_*` stable.
- `fpu_instr_received` is a registered or state-decoded output: glitch-free, exactly one cycle per op.
- Results return in request order; no reordering, no drop.
- Reset, asynchronous and at any time including mid-WAIT or RESP:
  - FSM to IDLE, FIFO emptied (pointers and count 0), counter 0.
  - All outputs 0 except `req_ready`=1.
  - The in-flight op is abandoned; no response is produced for it.

## Timing
- Issue pulse in cycle C means capture at the edge ending cycle C+LATENCY, and `rsp_valid` is high from cycle C+LATENCY+1.
- Request accepted at the edge ending cycle T into an empty, idle block: pop in cycle T+1, `fpu_instr_received` high in cycle T+2.
- Request-to-response latency is therefore LATENCY+3 cycles (13 at default).
- Sustained throughput with `rsp_ready` held high: one op per LATENCY+2 cycles.
- `fpu_input_*`/`fpu_op_mask` are stable from cycle C through the capture edge.
- `fifo_count` and `req_ready` are registered and update at the push/pop edge.
- Because the first op is popped immediately, DEPTH+1 requests can be accepted before `req_ready` falls while the response is stalled.

## Test plan
- **Reset values:** assert `rst` mid-cycle, with no clock edge. All outputs 0 immediately, `req_ready`=1, `fifo_count`=0.
- **Single op:** FMUL, a=0x3f800000, b=0x3f800000, tag=3. Bench FPU model drives `reg_lo`=0x3f800000 after 10 cycles.
  - One `fpu_instr_received` pulse two cycles after accept.
  - `rsp_valid` 11 cycles after the pulse, with `rsp_lo`=0x3f800000 and `rsp_tag`=3.
- **Fill/full:** `rsp_ready`=0, `req_valid` held with tags 0..5.
  - Exactly 5 accepted (tags 0..4); `req_ready` low with `fifo_count`=4; tag 5 waits.
  - Releasing `rsp_ready` drains tags 0..5 in order.
- **Backpressure:** hold `rsp_ready`=0 for 20 cycles in RESP (FMUL 0xbf000000 × 0x43fa2000, result 0xc37a2000).
  - `rsp_lo` stays 0xc37a2000 and no new issue pulse occurs while stalled, even with the FIFO non-empty.
- **Back-to-back:** 3 queued ops, `rsp_ready`=1. Issue pulses exactly 12 cycles apart; responses in tag order, one cycle each.
- **Reset mid-WAIT:** `rst` 5 cycles after an issue pulse, released, then idle for 20 cycles.
  - No `rsp_valid`, no further `fpu_instr_received`, `fifo_count`=0.
  - A subsequent request completes normally.
